// File: rtl/code_slew_ctrl_if.sv
// Slew command channel between the tracking loop (master) and the
// code-phase slew controller (slave).
interface code_slew_ctrl_if #(
    parameter int CNT_W = 11
);
    logic             slew_valid;
    logic             slew_ready;
    logic             slew_dir;
    logic [CNT_W-1:0] slew_chips;
    logic             slew_abort;

    modport master (
        output slew_valid,
        output slew_dir,
        output slew_chips,
        output slew_abort,
        input  slew_ready
    );

    modport slave (
        input  slew_valid,
        input  slew_dir,
        input  slew_chips,
        input  slew_abort,
        output slew_ready
    );
endinterface

// File: rtl/code_slew_ctrl.sv
// Code-phase slew controller: forwards NCO chip ticks as code enables and
// swallows or inserts enables on command, tracking the net phase offset.
module code_slew_ctrl #(
    parameter int CNT_W = 11,
    parameter int OFF_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    code_slew_ctrl_if.slave   slew,
    input  logic              chip_tick,
    input  logic              offset_clr,
    output logic              code_en,
    output logic              busy,
    output logic              slew_done,
    output logic [CNT_W-1:0]  remaining,
    output logic [OFF_W-1:0]  phase_offset
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RETARD  = 2'd1,
        ST_ADVANCE = 2'd2
    } state_t;

    state_t           state_r;
    logic             code_en_r;
    logic             busy_r;
    logic             slew_done_r;
    logic [CNT_W-1:0] remaining_r;
    logic [OFF_W-1:0] phase_offset_r;

    logic             accept_s;
    logic             abort_s;
    logic             dec_s;
    logic             up_s;
    logic             dn_s;
    logic             last_s;
    logic [OFF_W-1:0] offset_base_s;
    logic [OFF_W-1:0] offset_next_s;

    // Decide this cycle's count step; an abort cycle applies no step.
    always_comb begin
        accept_s = slew.slew_valid && (state_r == ST_IDLE);
        abort_s  = slew.slew_abort && (state_r != ST_IDLE);
        dec_s    = 1'b0;
        up_s     = 1'b0;
        dn_s     = 1'b0;
        case (state_r)
            ST_RETARD: begin
                if (!abort_s && chip_tick) begin
                    dec_s = 1'b1;
                    dn_s  = 1'b1;
                end else begin
                    dec_s = 1'b0;
                end
            end
            ST_ADVANCE: begin
                // A tick cycle carries the normal enable; the insert waits.
                if (!abort_s && !chip_tick) begin
                    dec_s = 1'b1;
                    up_s  = 1'b1;
                end else begin
                    dec_s = 1'b0;
                end
            end
            default: begin
                dec_s = 1'b0;
            end
        endcase
        last_s = dec_s && (remaining_r == CNT_W'(1));
    end

    // Offset clear and step combine so a cleared stepping cycle lands on +/-1.
    always_comb begin
        if (offset_clr) begin
            offset_base_s = {OFF_W{1'b0}};
        end else begin
            offset_base_s = phase_offset_r;
        end
        if (up_s) begin
            offset_next_s = offset_base_s + OFF_W'(1);
        end else if (dn_s) begin
            offset_next_s = offset_base_s - OFF_W'(1);
        end else begin
            offset_next_s = offset_base_s;
        end
    end

    // Slew FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            code_en_r      <= 1'b0;
            busy_r         <= 1'b0;
            slew_done_r    <= 1'b0;
            remaining_r    <= {CNT_W{1'b0}};
            phase_offset_r <= {OFF_W{1'b0}};
        end else begin
            slew_done_r    <= 1'b0;
            phase_offset_r <= offset_next_s;
            case (state_r)
                ST_IDLE: begin
                    code_en_r <= chip_tick;
                    if (accept_s) begin
                        if (slew.slew_chips == {CNT_W{1'b0}}) begin
                            slew_done_r <= 1'b1;
                        end else begin
                            state_r     <= slew.slew_dir ? ST_ADVANCE : ST_RETARD;
                            busy_r      <= 1'b1;
                            remaining_r <= slew.slew_chips;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_RETARD, ST_ADVANCE: begin
                    if (abort_s) begin
                        state_r     <= ST_IDLE;
                        busy_r      <= 1'b0;
                        remaining_r <= {CNT_W{1'b0}};
                        code_en_r   <= chip_tick;
                    end else begin
                        code_en_r <= (state_r == ST_ADVANCE);
                        if (dec_s) begin
                            remaining_r <= remaining_r - CNT_W'(1);
                        end else begin
                            remaining_r <= remaining_r;
                        end
                        if (last_s) begin
                            state_r     <= ST_IDLE;
                            busy_r      <= 1'b0;
                            slew_done_r <= 1'b1;
                        end else begin
                            busy_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    busy_r      <= 1'b0;
                    code_en_r   <= 1'b0;
                    remaining_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign slew.slew_ready = (state_r == ST_IDLE);
    assign code_en         = code_en_r;
    assign busy            = busy_r;
    assign slew_done       = slew_done_r;
    assign remaining       = remaining_r;
    assign phase_offset    = phase_offset_r;

endmodule

// File: tb/tb_code_slew_ctrl.sv
// Self-checking bench for code_slew_ctrl: a 16-bit and a 4-bit offset instance
// share stimulus and are compared against a chip-count reference model.
module tb_code_slew_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick, valid, dir, abort, clr;
    logic [10:0] chips;

    logic        code_en, busy, slew_done;
    logic [10:0] remaining;
    logic [15:0] phase_offset;
    logic        code_en4, busy4, slew_done4;
    logic [10:0] remaining4;
    logic [3:0]  phase_offset4;

    int errors = 0;
    int checks = 0;

    // reference model: mode 0 idle, 1 retard, 2 advance
    int   m_mode, m_rem, m_off;
    logic m_ce, m_done;

    code_slew_ctrl_if #(.CNT_W(11)) sif ();
    code_slew_ctrl_if #(.CNT_W(11)) sif4 ();

    assign sif.slew_valid  = valid;
    assign sif.slew_dir    = dir;
    assign sif.slew_chips  = chips;
    assign sif.slew_abort  = abort;
    assign sif4.slew_valid = valid;
    assign sif4.slew_dir   = dir;
    assign sif4.slew_chips = chips;
    assign sif4.slew_abort = abort;

    code_slew_ctrl #(.CNT_W(11), .OFF_W(16)) dut (
        .clk(clk), .rst(rst), .slew(sif.slave), .chip_tick(tick), .offset_clr(clr),
        .code_en(code_en), .busy(busy), .slew_done(slew_done),
        .remaining(remaining), .phase_offset(phase_offset)
    );

    code_slew_ctrl #(.CNT_W(11), .OFF_W(4)) dut4 (
        .clk(clk), .rst(rst), .slew(sif4.slave), .chip_tick(tick), .offset_clr(clr),
        .code_en(code_en4), .busy(busy4), .slew_done(slew_done4),
        .remaining(remaining4), .phase_offset(phase_offset4)
    );

    always #5 clk = ~clk;

    function automatic logic [34:0] got_vec();
        return {code_en, slew_done, busy, sif.slew_ready, remaining, phase_offset, phase_offset4};
    endfunction

    function automatic logic [34:0] exp_vec();
        return {m_ce, m_done, (m_mode != 0), (m_mode == 0), 11'(m_rem), 16'(m_off), 4'(m_off)};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_rem = 0; m_off = 0; m_ce = 1'b0; m_done = 1'b0;
    endtask

    // One clock cycle of stimulus; the model advances by the chip-count rules.
    task automatic drive(input logic t, input logic v, input logic d, input int c,
                         input logic a, input logic cl);
        int nmode, nrem, stp;
        logic nce, nd;
        tick = t; valid = v; dir = d; chips = c[10:0]; abort = a; clr = cl;
        nmode = m_mode; nrem = m_rem; nce = t; nd = 1'b0; stp = 0;
        if (m_mode == 0) begin
            if (v) begin
                if (c == 0) nd = 1'b1;
                else begin nmode = d ? 2 : 1; nrem = c; end
            end
        end else if (a) begin
            nmode = 0; nrem = 0;
        end else if (m_mode == 1) begin
            nce = 1'b0;
            if (t) begin stp = -1; nrem = m_rem - 1; end
        end else begin
            nce = 1'b1;
            if (!t) begin stp = 1; nrem = m_rem - 1; end
        end
        if (m_mode != 0 && !a && stp != 0 && nrem == 0) begin
            nmode = 0; nd = 1'b1;
        end
        @(posedge clk); #1;
        m_off  = (cl ? 0 : m_off) + stp;
        m_mode = nmode; m_rem = nrem; m_ce = nce; m_done = nd;
    endtask

    task automatic test_reset();
        checks++;
        if (got_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset: got %h expected %h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_passthrough();
        int cnt = 0;
        for (int i = 0; i < 32; i++) begin
            drive(i % 4 == 1, 1'b0, 1'b0, 0, 1'b0, i == 0);
            if (code_en) cnt++;
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL passthrough cyc %0d: got %h expected %h", i, got_vec(), exp_vec());
            end
        end
        checks++;
        if (cnt !== 8 || phase_offset !== 16'h0000) begin
            errors++;
            $display("FAIL passthrough totals: got pulses=%0d off=%h expected 8 0000", cnt, phase_offset);
        end
    endtask

    task automatic test_retard();
        int cnt = 0, dones = 0;
        for (int i = 0; i < 28; i++) begin
            drive(i % 4 == 1, i == 0, 1'b0, 3, 1'b0, 1'b0);
            if (code_en) cnt++;
            if (slew_done) dones++;
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL retard cyc %0d: got %h expected %h", i, got_vec(), exp_vec());
            end
        end
        checks++;
        if (cnt !== 4 || dones !== 1 || phase_offset !== 16'hFFFD) begin
            errors++;
            $display("FAIL retard totals: got pulses=%0d done=%0d off=%h expected 4 1 fffd",
                     cnt, dones, phase_offset);
        end
    endtask

    task automatic test_advance();
        int cnt = 0, dones = 0;
        for (int i = 0; i < 16; i++) begin
            drive(i % 2 == 0, i == 0, 1'b1, 5, 1'b0, i == 0);
            if (code_en) cnt++;
            if (slew_done) dones++;
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL advance cyc %0d: got %h expected %h", i, got_vec(), exp_vec());
            end
        end
        checks++;
        if (cnt !== 13 || dones !== 1 || phase_offset !== 16'h0005) begin
            errors++;
            $display("FAIL advance totals: got pulses=%0d done=%0d off=%h expected 13 1 0005",
                     cnt, dones, phase_offset);
        end
    endtask

    task automatic test_zero_abort();
        int dones = 0, busy_seen = 0, tk = 0, ce = 0;
        bit aborted = 0;
        logic a;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, i == 0, 1'b0, 0, 1'b0, i == 0);
            if (slew_done) dones++;
            if (busy) busy_seen++;
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL zero cyc %0d: got %h expected %h", i, got_vec(), exp_vec());
            end
        end
        checks++;
        if (dones !== 1 || busy_seen !== 0) begin
            errors++;
            $display("FAIL zero totals: got done=%0d busy=%0d expected 1 0", dones, busy_seen);
        end
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            a = (m_mode == 1 && m_rem == 6);
            if (a) aborted = 1;
            drive(i % 2 == 1, i == 0, 1'b0, 10, a, 1'b0);
            if (slew_done) dones++;
            if (aborted) begin
                if (tick) tk++;
                if (code_en) ce++;
            end
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL abort cyc %0d: got %h expected %h", i, got_vec(), exp_vec());
            end
        end
        checks++;
        if (dones !== 0 || remaining !== 11'd0 || phase_offset !== 16'hFFFC || tk !== ce || !aborted) begin
            errors++;
            $display("FAIL abort totals: got done=%0d rem=%0d off=%h ticks=%0d en=%0d expected 0 0 fffc equal",
                     dones, remaining, phase_offset, tk, ce);
        end
    endtask

    task automatic test_wrap_clear();
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, i == 0, 1'b1, 7, 1'b0, i == 0);
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL wrap adv7 cyc %0d: got %h expected %h", i, got_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, i == 0, 1'b1, 2, 1'b0, 1'b0);
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL wrap adv2 cyc %0d: got %h expected %h", i, got_vec(), exp_vec());
            end
        end
        checks++;
        if (phase_offset4 !== 4'h9 || phase_offset !== 16'h0009) begin
            errors++;
            $display("FAIL wrap value: got %h/%h expected 9/0009", phase_offset4, phase_offset);
        end
        drive(1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b1);
        checks++;
        if (phase_offset4 !== 4'hF || phase_offset !== 16'hFFFF || remaining !== 11'd2) begin
            errors++;
            $display("FAIL clear+step: got off=%h/%h rem=%0d expected f/ffff 2",
                     phase_offset4, phase_offset, remaining);
        end
        for (int i = 0; i < 8; i++) begin
            drive(i % 2 == 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL clear tail cyc %0d: got %h expected %h", i, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        int accepts = 0;
        for (int i = 0; i < 400; i++) begin
            if (m_mode == 0 && valid) accepts++;
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 6), $urandom_range(0, 19) == 0, $urandom_range(0, 15) == 0);
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL back_to_back cyc %0d: got %h expected %h", i, got_vec(), exp_vec());
            end
        end
        checks++;
        if (accepts < 20) begin
            errors++;
            $display("FAIL back_to_back accepts: got %0d expected >= 20", accepts);
        end
    endtask

    task automatic test_reset_midslew();
        int dones = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, i == 0, 1'b1, 10, 1'b0, i == 0);
        end
        checks++;
        if (remaining !== 11'd6 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midslew setup: got rem=%0d busy=%b expected 6 1", remaining, busy);
        end
        #2 rst = 1'b1;
        #1 model_reset();
        checks++;
        if (got_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL midslew async reset: got %h expected %h", got_vec(), exp_vec());
        end
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(i % 3 == 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
            if (slew_done) dones++;
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL post reset cyc %0d: got %h expected %h", i, got_vec(), exp_vec());
            end
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL post reset done: got %0d expected 0", dones);
        end
    endtask

    initial begin
        rst = 1'b1;
        tick = 1'b0; valid = 1'b0; dir = 1'b0; chips = 11'd0; abort = 1'b0; clr = 1'b0;
        model_reset();
        #12;
        test_reset();
        @(posedge clk); #1 rst = 1'b0;
        test_passthrough();
        test_retard();
        test_advance();
        test_zero_abort();
        test_wrap_clear();
        test_back_to_back();
        test_reset_midslew();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
